// File: rtl/stopwatch_timer_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_timer_ctrl
//
// Stopwatch/timer controller. It contains the run/pause/idle FSM, a clock
// prescaler and the count register. The count runs up (stopwatch) or down to
// zero (timer). The block drives the count value directly to the display path.
//
// Optional feature macro: TIMER_LAP_EN
//   defined   : lap captures the pre-edge count while RUNNING or PAUSED.
//   undefined : lap is ignored; lap_val and lap_valid are tied to 0.
//
// Parameters
//   CNT_W     width of count, load_val and lap_val
//   PRESCALE  clock cycles per count step (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      start from IDLE/DONE, resume from PAUSED
//   stop       pause while RUNNING
//   clear      return to IDLE from any state (keeps the latched mode)
//   mode       0 = up-count, 1 = down-count (sampled when a start is accepted)
//   load_val   down-count start value (sampled with mode)
//   lap        lap-capture strobe
//   count      current count value
//   status     00 IDLE, 01 RUNNING, 10 PAUSED, 11 DONE
//   tick       one-cycle pulse with each new count value from a step
//   ovf        one-cycle pulse when an up-count wraps to 0
//   done       one-cycle pulse on entry to DONE
//   lap_val    captured count
//   lap_valid  set by the first capture, cleared by rst/clear
// ---------------------------------------------------------------------------
module stopwatch_timer_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PRESCALE = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode,
  input  logic [CNT_W-1:0] load_val,
  input  logic             lap,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       status,
  output logic             tick,
  output logic             ovf,
  output logic             done,
  output logic [CNT_W-1:0] lap_val,
  output logic             lap_valid
);

  localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic            mode_q;
  logic            terminal;
  logic            start_ok;

  assign terminal = (presc == PRE_MAX);
  // start together with stop never causes a transition
  assign start_ok = start & ~stop;
  assign status   = state;

  always_ff @(posedge clk) begin
    tick <= 1'b0;
    ovf  <= 1'b0;
    done <= 1'b0;
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      presc  <= '0;
      mode_q <= 1'b0;
    end else if (clear) begin
      state <= S_IDLE;
      count <= '0;
      presc <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            mode_q <= mode;
            presc  <= '0;
            if (mode && (load_val == '0)) begin
              // a zero-length countdown finishes immediately
              state <= S_DONE;
              count <= '0;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              count <= mode ? load_val : '0;
            end
          end
        end

        S_RUN: begin
          if (terminal) begin
            // a terminal cycle steps even when stop is sampled with it
            presc <= '0;
            tick  <= 1'b1;
            if (mode_q) begin
              count <= count - CNT_W'(1);
              if (count == CNT_W'(1)) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else if (stop) begin
                state <= S_PAUSE;
              end
            end else begin
              count <= count + CNT_W'(1);
              ovf   <= &count;
              if (stop) begin
                state <= S_PAUSE;
              end
            end
          end else if (stop) begin
            // freeze the prescaler so the resumed period is not shortened
            state <= S_PAUSE;
          end else begin
            presc <= presc + PW'(1);
          end
        end

        S_PAUSE: begin
          if (start_ok) begin
            state <= S_RUN;
          end
        end
      endcase
    end
  end

`ifdef TIMER_LAP_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lap_val   <= '0;
      lap_valid <= 1'b0;
    end else if (lap && ((state == S_RUN) || (state == S_PAUSE))) begin
      lap_val   <= count;
      lap_valid <= 1'b1;
    end
  end
`else
  assign lap_val   = '0;
  assign lap_valid = 1'b0;

  logic unused_lap;
  assign unused_lap = lap;
`endif

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_timer_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned P   = 4;
  localparam int          PI  = 4;
  localparam int          MOD = 256;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DONE = 3;

  logic         clk = 1'b0;
  logic         rst, start, stop, clear, mode, lap;
  logic [W-1:0] load_val;
  logic [W-1:0] count, lap_val;
  logic [1:0]   status;
  logic         tick, ovf, done, lap_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_timer_ctrl #(.CNT_W(W), .PRESCALE(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .mode     (mode),
    .load_val (load_val),
    .lap      (lap),
    .count    (count),
    .status   (status),
    .tick     (tick),
    .ovf      (ovf),
    .done     (done),
    .lap_val  (lap_val),
    .lap_valid(lap_valid)
  );

  typedef struct {
    bit r, s, p, c, m;
    int ld;
    bit l;
  } inp_t;

  typedef struct {
    inp_t iv;
    int   e_cnt;
    int   e_st;
    bit   e_tick, e_ovf, e_done;
  } vec_t;

  vec_t vecs[$];

  // Reference model: count is derived from the number of productive running
  // cycles since the start, divided by the period.
  int m_st = ST_IDLE, m_cnt = 0, m_elapsed = 0, m_base = 0, m_lapv = 0;
  bit m_down = 0, m_tick = 0, m_ovf = 0, m_done = 0, m_lapok = 0;

  function automatic void model_step(input inp_t i);
    bit adv;
    int n;
    m_tick = 0; m_ovf = 0; m_done = 0;
    if (i.r) begin
      m_st = ST_IDLE; m_cnt = 0; m_elapsed = 0; m_base = 0; m_down = 0;
      m_lapv = 0; m_lapok = 0;
      return;
    end
    if (i.c) begin
      m_st = ST_IDLE; m_cnt = 0; m_elapsed = 0; m_lapv = 0; m_lapok = 0;
      return;
    end
`ifdef TIMER_LAP_EN
    if (i.l && (m_st == ST_RUN || m_st == ST_PAUSE)) begin
      m_lapv = m_cnt; m_lapok = 1;
    end
`endif
    case (m_st)
      ST_IDLE, ST_DONE: begin
        if (i.s && !i.p) begin
          m_down = i.m; m_elapsed = 0;
          m_base = i.m ? i.ld : 0;
          m_cnt = m_base;
          if (i.m && i.ld == 0) begin m_st = ST_DONE; m_done = 1; end
          else m_st = ST_RUN;
        end
      end
      ST_RUN: begin
        adv = !i.p || ((m_elapsed % PI) == PI - 1);
        if (adv) m_elapsed++;
        if (adv && (m_elapsed % PI) == 0) begin
          m_tick = 1;
          n = m_elapsed / PI;
          if (m_down) begin
            m_cnt = m_base - n;
            if (m_cnt == 0) begin m_st = ST_DONE; m_done = 1; end
          end else begin
            m_cnt = (m_base + n) % MOD;
            m_ovf = (m_cnt == 0);
          end
        end
        if (i.p && m_st == ST_RUN) m_st = ST_PAUSE;
      end
      ST_PAUSE: if (i.s && !i.p) m_st = ST_RUN;
      default: ;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model count",     32'(count),     32'(m_cnt));
    chk("model status",    32'(status),    32'(m_st));
    chk("model tick",      32'(tick),      32'(m_tick));
    chk("model ovf",       32'(ovf),       32'(m_ovf));
    chk("model done",      32'(done),      32'(m_done));
    chk("model lap_val",   32'(lap_val),   32'(m_lapv));
    chk("model lap_valid", 32'(lap_valid), 32'(m_lapok));
  endtask

  function automatic inp_t mk(bit r, bit s, bit p, bit c, bit m, int ld, bit l);
    inp_t i;
    i.r = r; i.s = s; i.p = p; i.c = c; i.m = m; i.ld = ld; i.l = l;
    return i;
  endfunction

  task automatic step(input inp_t i);
    rst = i.r; start = i.s; stop = i.p; clear = i.c; mode = i.m;
    load_val = W'(i.ld); lap = i.l;
    model_step(i);
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(mk(0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic tv(input bit r, s, p, c, m, input int ld,
                    input int ec, es, input bit et, eo, ed);
    vec_t v;
    v.iv = mk(r, s, p, c, m, ld, 0);
    v.e_cnt = ec; v.e_st = es; v.e_tick = et; v.e_ovf = eo; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic tv_idle(input int n, input int ec, es);
    for (int k = 0; k < n; k++) tv(0, 0, 0, 0, 0, 0, ec, es, 0, 0, 0);
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; clear = 0; mode = 0; load_val = '0; lap = 0;

    // up-count start, first ticks, then countdown from 3 and zero-length countdown
    tv(1, 0, 0, 0, 0, 0, 0, ST_IDLE, 0, 0, 0);
    tv(0, 1, 0, 0, 0, 0, 0, ST_RUN, 0, 0, 0);
    tv_idle(3, 0, ST_RUN);
    tv(0, 0, 0, 0, 0, 0, 1, ST_RUN, 1, 0, 0);
    tv_idle(3, 1, ST_RUN);
    tv(0, 0, 0, 0, 0, 0, 2, ST_RUN, 1, 0, 0);
    tv_idle(3, 2, ST_RUN);
    tv(0, 0, 0, 0, 0, 0, 3, ST_RUN, 1, 0, 0);
    tv(0, 0, 0, 1, 0, 0, 0, ST_IDLE, 0, 0, 0);
    tv(0, 1, 0, 0, 1, 3, 3, ST_RUN, 0, 0, 0);
    tv_idle(3, 3, ST_RUN);
    tv(0, 0, 0, 0, 0, 0, 2, ST_RUN, 1, 0, 0);
    tv_idle(3, 2, ST_RUN);
    tv(0, 0, 0, 0, 0, 0, 1, ST_RUN, 1, 0, 0);
    tv_idle(3, 1, ST_RUN);
    tv(0, 0, 0, 0, 0, 0, 0, ST_DONE, 1, 0, 1);
    tv(0, 0, 0, 0, 0, 0, 0, ST_DONE, 0, 0, 0);
    tv(0, 1, 0, 0, 1, 3, 3, ST_RUN, 0, 0, 0);
    tv(0, 0, 0, 1, 0, 0, 0, ST_IDLE, 0, 0, 0);
    tv(0, 1, 0, 0, 1, 0, 0, ST_DONE, 0, 0, 1);
    tv(0, 0, 0, 0, 0, 0, 0, ST_DONE, 0, 0, 0);

    foreach (vecs[k]) begin
      step(vecs[k].iv);
      chk($sformatf("vec%0d count", k),  32'(count),  32'(vecs[k].e_cnt));
      chk($sformatf("vec%0d status", k), 32'(status), 32'(vecs[k].e_st));
      chk($sformatf("vec%0d tick", k),   32'(tick),   32'(vecs[k].e_tick));
      chk($sformatf("vec%0d ovf", k),    32'(ovf),    32'(vecs[k].e_ovf));
      chk($sformatf("vec%0d done", k),   32'(done),   32'(vecs[k].e_done));
    end

    // pause keeps the partial period
    step(mk(1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 0));
    idle(8);
    chk("pause count2", 32'(count), 32'd2);
    idle(2);
    step(mk(0, 0, 1, 0, 0, 0, 0));
    chk("pause status", 32'(status), 32'(ST_PAUSE));
    idle(20);
    chk("pause hold count", 32'(count), 32'd2);
    chk("pause hold status", 32'(status), 32'(ST_PAUSE));
    step(mk(0, 1, 0, 0, 0, 0, 0));
    chk("resume status", 32'(status), 32'(ST_RUN));
    idle(1);
    chk("resume count early", 32'(count), 32'd2);
    idle(1);
    chk("resume count3", 32'(count), 32'd3);
    chk("resume tick", 32'(tick), 32'd1);
    step(mk(0, 0, 1, 0, 0, 0, 0));
    step(mk(0, 1, 1, 0, 0, 0, 0));
    chk("paused start+stop", 32'(status), 32'(ST_PAUSE));

    // up-count wrap
    step(mk(1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 0));
    idle(1023);
    chk("wrap count255", 32'(count), 32'd255);
    idle(1);
    chk("wrap count0", 32'(count), 32'd0);
    chk("wrap ovf", 32'(ovf), 32'd1);
    chk("wrap tick", 32'(tick), 32'd1);
    chk("wrap status", 32'(status), 32'(ST_RUN));
    idle(1);
    chk("wrap ovf pulse", 32'(ovf), 32'd0);

    // clear on a terminal cycle suppresses the step
    step(mk(1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 0));
    idle(20);
    chk("clr count5", 32'(count), 32'd5);
    idle(3);
    step(mk(0, 0, 0, 1, 0, 0, 0));
    chk("clr status", 32'(status), 32'(ST_IDLE));
    chk("clr count", 32'(count), 32'd0);
    chk("clr tick", 32'(tick), 32'd0);

    // reset mid-countdown
    step(mk(0, 1, 0, 0, 1, 50, 0));
    idle(5);
    step(mk(0, 0, 0, 0, 0, 0, 1));
    idle(5);
    step(mk(1, 0, 0, 0, 0, 0, 0));
    chk("rst count", 32'(count), 32'd0);
    chk("rst status", 32'(status), 32'(ST_IDLE));
    chk("rst flags", 32'({tick, ovf, done, lap_valid}), 32'd0);
    chk("rst lap_val", 32'(lap_val), 32'd0);

    // lap capture
    step(mk(0, 1, 0, 0, 0, 0, 0));
    idle(28);
    chk("lap count7", 32'(count), 32'd7);
    step(mk(0, 0, 0, 0, 0, 0, 1));
`ifdef TIMER_LAP_EN
    chk("lap_val", 32'(lap_val), 32'd7);
    chk("lap_valid", 32'(lap_valid), 32'd1);
`else
    chk("lap_val", 32'(lap_val), 32'd0);
    chk("lap_valid", 32'(lap_valid), 32'd0);
`endif
    idle(3);
    chk("lap count8", 32'(count), 32'd8);

    // randomized traffic against the model
    step(mk(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4000; k++) begin
      inp_t i;
      i.r  = ($urandom_range(0, 499) == 0);
      i.c  = ($urandom_range(0, 59) == 0);
      i.s  = ($urandom_range(0, 7) == 0);
      i.p  = ($urandom_range(0, 9) == 0);
      i.m  = $urandom_range(0, 1) != 0;
      i.ld = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 5));
      i.l  = ($urandom_range(0, 9) == 0);
      step(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer_ctrl.md
# stopwatch_timer_ctrl

Parametrised stopwatch/timer controller that combines the run/pause/idle control FSM with its own prescaler and a count register. It supports up-count (stopwatch) and down-count (timer) modes, end-of-countdown detection and, optionally, lap capture. It sits between the debounced button inputs and the display/segment logic, and drives the counter value directly rather than just an enable.

## Interface
- `CNT_W`, 16: width of the count register and `load_val`.
- `PRESCALE`, 1000: clock cycles per count step; legal range ≥1.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: start from IDLE/DONE, resume from PAUSED; level-sampled every cycle.
- `stop` in 1: pause while RUNNING.
- `clear` in 1: logical return to IDLE from any state.
- `mode` in 1: 0 = up-count, 1 = down-count; sampled only when a start is accepted from IDLE or DONE.
- `load_val` in CNT_W: down-count start value; sampled with `mode`.
- `lap` in 1: lap-capture strobe.
- `count` out CNT_W: current count.
- `status` out 2: state encoding, where IDLE=00, RUNNING=01, PAUSED=10, DONE=11.
- `tick` out 1: one-cycle pulse, coincident with each new `count` value produced by a step.
- `ovf` out 1: one-cycle pulse when an up-count wraps.
- `done` out 1: one-cycle pulse on entry to DONE.
- `lap_val` out CNT_W: captured count.
- `lap_valid` out 1: set by the first capture; cleared by `rst`/`clear`.

## Operation
**Reset.** `rst` has top priority. On reset: state IDLE, `count`=0, prescaler=0, latched mode=0, `tick`/`ovf`/`done`=0, `lap_val`=0, `lap_valid`=0.

**Priority.** `clear` > `stop` > `start`.
- `clear` acts like `rst`, except it does not touch the latched mode.
- `clear` suppresses any step in the same cycle.

**IDLE.** `count` holds 0.
- `start` (with `stop`=0) → RUNNING.
- The start loads `count` with 0 (mode 0) or `load_val` (mode 1) and zeroes the prescaler.
- Mode 1 with `load_val`=0 → DONE directly, and `done` pulses.

**RUNNING.**
- The prescaler counts 0..PRESCALE-1. At terminal it wraps to 0 and `count` steps.
- Up-count step: `count`+1. Stepping from 2^CNT_W-1 wraps to 0 and pulses `ovf`.
- Down-count step: `count`-1. Reaching 0 moves the state to DONE in the same edge and pulses `done`.
- `stop` → PAUSED. The prescaler and `count` freeze at their current values.
- A step whose terminal cycle coincides with `stop` still occurs.
- `start` is ignored.

**PAUSED.**
- `start` → RUNNING. The prescaler resumes from its held value, so no partial period is lost.
- `stop` is ignored.
- Simultaneous `start`+`stop`: stays PAUSED.

**DONE.** `count` holds 0.
- `start` → RUNNING, with a fresh sample of `mode`/`load_val` (same rules as from IDLE).
- `stop` is ignored.

**Simultaneous `start`+`stop` in IDLE or DONE.** No transition.

**Illegal state.** None reachable with 2-bit encoding (all four are used); no recovery needed.

**Widths.**
- The prescaler is max(1,$clog2(PRESCALE)) bits.
- `count` arithmetic is modulo 2^CNT_W. Down-count never goes below 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `status` changes on the edge after the cycle in which the controlling input is sampled (1-cycle latency).
- First step after a start from IDLE: `count` changes PRESCALE cycles after the `status`=01 edge. `tick` is high in that same cycle.
- With PRESCALE=1, `count` steps every RUNNING cycle.
- `done` is high in the first cycle `status`=11.
- `ovf` is high in the cycle `count` becomes 0 via wrap.
- `lap_val` and `lap_valid` update on the edge after `lap` is sampled.

## Configuration
- `TIMER_LAP_EN` defined:
  - `lap` asserted in RUNNING or PAUSED captures the pre-edge `count` into `lap_val` and sets `lap_valid`. Counting is unaffected.
  - `lap` is ignored in IDLE and DONE.
  - `lap` in the same cycle as a step captures the old value.
- `TIMER_LAP_EN` undefined:
  - Ports remain present.
  - `lap` is ignored.
  - `lap_val` and `lap_valid` are tied to 0.
  - No capture register is synthesised.

## Test plan
All scenarios use CNT_W=8 and PRESCALE=4.
1. `rst`, `mode`=0, `start` pulse → `status`=01 next cycle. `count`=1 with `tick` 4 cycles later; `count`=3 after 12 RUNNING cycles; `tick` every 4th cycle.
2. `mode`=1, `load_val`=3, `start` → `count`=3, reaching 0 after 12 cycles with `status`=11 and a single-cycle `done`. A second `start` reloads 3 and gives `status`=01. Separately, `load_val`=0 with `start` → `status`=11 with `done` directly.
3. Up-count, `stop` 2 cycles after `count`=2 → `status`=10 and `count` holds 2 for 20 cycles. `start` → `count`=3 exactly 2 RUNNING cycles later.
4. Up-count from reset for 256 steps (1024 cycles) → `count` goes 255→0 with a one-cycle `ovf` and `tick`. `status` stays 01.
5. Priority cases:
   - `clear` mid-run at `count`=5 → `status`=00, `count`=0 next cycle, no `tick`.
   - `start`+`stop` in PAUSED → stays 10.
   - `rst` mid-countdown → all outputs at reset values.
6. With `TIMER_LAP_EN`: `lap` at `count`=7 → `lap_val`=7 and `lap_valid`=1, counting continues to 8. With the macro undefined, the same stimulus gives `lap_val`=0 and `lap_valid`=0.
